exc_ctrl: RTL and testbench

Exception/interrupt arbiter and pipeline-flush sequencer for the 5-stage MIPS core. Samples MEM-stage exception flags and synchronised hardware interrupts, then picks the single highest-priority event. Drives the excepttype/EPC-source/delay-slot inputs of the CP0 register file, the pipeline flush and redirect PC, and merges ID/EX stall requests into the 6-bit stall vector.

---
 rtl/exc_ctrl_pkg.sv | 41 ++++
 rtl/exc_ctrl_int_sync.sv | 29 ++
 rtl/exc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared constants for the exception/interrupt controller.
//   - excepttype codes handed to the CP0 register file
//   - stall vector encodings {wb,mem,ex,id,if,pc}
//   - FSM state encodings
//   - CP0 Status/Cause bit positions
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_RI      = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TAKE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IV     = 23;

  // EX stall freezes everything up to and including EX; ID stall up to ID.
  function automatic logic [5:0] stall_merge(input logic req_ex, input logic req_id);
    logic [5:0] v;
    v = STALL_NONE;
    if (req_ex)      v = STALL_EX;
    else if (req_id) v = STALL_ID;
    return v;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// exc_ctrl_int_sync: SYNC_STAGES-deep flop chain for the six asynchronous
// hardware interrupt lines.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-low
//   int_i      in   [5:0] raw interrupt lines
//   int_sync_o out  [5:0] synchronised interrupt lines
module exc_ctrl_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] int_i,
  output logic [5:0] int_sync_o
);

  logic [SYNC_STAGES-1:0][5:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], int_i};
    end
  end

  assign int_sync_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt arbiter and pipeline-flush sequencer for the
// 5-stage MIPS core.
// Optional build macro: EXC_CTRL_SPLIT_VEC_EN -- when defined, an interrupt
// with Cause.IV=1 redirects to EXC_VECTOR+0x200.
// Ports:
//   clk, rst (async, active-low)
//   int_i[5:0], timer_int_i          hardware / timer interrupts
//   status_i, cause_i, epc_i         CP0 register views
//   mem_valid_i, mem_pc_i, mem_in_delayslot_i, exc_*_i   MEM-stage info
//   stallreq_id_i, stallreq_ex_i     stall requests
//   cp0_int_o                        synchronised interrupts to CP0
//   excepttype_o, current_inst_address_o, is_in_delayslot_o  to CP0
//   flush_o, new_pc_o                pipeline flush / redirect
//   stall_o                          {wb,mem,ex,id,if,pc} stall vector
//   busy_o                           sequencer active
//
// state    | meaning
// ST_IDLE  | arbitrating MEM-stage events, merging stall requests
// ST_TAKE  | excepttype_o valid for CP0, flush asserted
// ST_FLUSH | flush held for the remaining FLUSH_CYCLES-1 cycles
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        exc_syscall_i,
  input  logic        exc_ri_i,
  input  logic        exc_trap_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  output logic [5:0]  cp0_int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_address_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic        busy_o
);

  // Counter reload for the FLUSH state; only meaningful when FLUSH_CYCLES > 1.
  localparam logic [1:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_excepttype;
  logic [31:0] r_cur_addr;
  logic        r_delayslot;
  logic [31:0] r_new_pc;

  logic [5:0]  w_int_sync;
  logic        w_int_pend;
  logic        w_event;
  logic [31:0] w_code;
  logic [31:0] w_new_pc;
  logic        w_accept;
  logic        w_unused;

  exc_ctrl_int_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk       (clk),
    .rst       (rst),
    .int_i     (int_i),
    .int_sync_o(w_int_sync)
  );

  // Gated with rst so the timer path cannot leak through while in reset.
  assign cp0_int_o = rst ? {w_int_sync[5] | timer_int_i, w_int_sync[4:0]} : 6'b0;

  assign w_int_pend = status_i[STATUS_IE] & ~status_i[STATUS_EXL] &
                      (|(cause_i[CAUSE_IP_HI:CAUSE_IP_LO] & status_i[STATUS_IM_HI:STATUS_IM_LO]));

  always_comb begin
    w_event = 1'b1;
    w_code  = EXC_NONE;
    if (w_int_pend)         w_code = EXC_INT;
    else if (exc_syscall_i) w_code = EXC_SYSCALL;
    else if (exc_ri_i)      w_code = EXC_RI;
    else if (exc_trap_i)    w_code = EXC_TRAP;
    else if (exc_ov_i)      w_code = EXC_OV;
    else if (exc_eret_i)    w_code = EXC_ERET;
    else                    w_event = 1'b0;
  end

  always_comb begin
    w_new_pc = EXC_VECTOR;
    if (w_code == EXC_ERET) begin
      w_new_pc = epc_i;
    end
`ifdef EXC_CTRL_SPLIT_VEC_EN
    else if ((w_code == EXC_INT) && cause_i[CAUSE_IV]) begin
      w_new_pc = EXC_VECTOR + 32'h200;
    end
`else
`endif
  end

  assign w_accept = (r_state == ST_IDLE) & mem_valid_i & w_event;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 2'd0;
      r_excepttype <= '0;
      r_cur_addr   <= '0;
      r_delayslot  <= 1'b0;
      r_new_pc     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_TAKE;
            r_excepttype <= w_code;
            r_cur_addr   <= mem_pc_i;
            r_delayslot  <= mem_in_delayslot_i;
            r_new_pc     <= w_new_pc;
          end
        end
        ST_TAKE: begin
          r_excepttype <= EXC_NONE;
          if (FLUSH_CYCLES > 1) begin
            r_state <= ST_FLUSH;
            r_cnt   <= CNT_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == 2'd0) r_state <= ST_IDLE;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_excepttype <= EXC_NONE;
        end
      endcase
    end
  end

  assign excepttype_o           = r_excepttype;
  assign current_inst_address_o = r_cur_addr;
  assign is_in_delayslot_o      = r_delayslot;
  assign new_pc_o               = r_new_pc;
  assign busy_o                 = (r_state != ST_IDLE);
  assign flush_o                = (r_state == ST_TAKE) | (r_state == ST_FLUSH);

  // Stall requests belong to instructions that are flushed once busy.
  assign stall_o = (rst && (r_state == ST_IDLE)) ? stall_merge(stallreq_ex_i, stallreq_id_i)
                                                  : STALL_NONE;

  assign w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam int          FC  = 3;
  localparam logic [31:0] VEC = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i, mem_pc_i;
  logic        mem_valid_i, mem_in_delayslot_i;
  logic        exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i;
  logic        stallreq_id_i, stallreq_ex_i;
  logic [5:0]  cp0_int_o, stall_o;
  logic [31:0] excepttype_o, current_inst_address_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_left;
  logic [31:0] m_exc, m_pc, m_newpc;
  logic        m_ds;
  logic [5:0]  m_h0, m_h1;

  always #5 clk = ~clk;

  exc_ctrl #(
    .EXC_VECTOR  (VEC),
    .FLUSH_CYCLES(FC),
    .SYNC_STAGES (2)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .int_i                 (int_i),
    .timer_int_i           (timer_int_i),
    .status_i              (status_i),
    .cause_i               (cause_i),
    .epc_i                 (epc_i),
    .mem_valid_i           (mem_valid_i),
    .mem_pc_i              (mem_pc_i),
    .mem_in_delayslot_i    (mem_in_delayslot_i),
    .exc_syscall_i         (exc_syscall_i),
    .exc_ri_i              (exc_ri_i),
    .exc_trap_i            (exc_trap_i),
    .exc_ov_i              (exc_ov_i),
    .exc_eret_i            (exc_eret_i),
    .stallreq_id_i         (stallreq_id_i),
    .stallreq_ex_i         (stallreq_ex_i),
    .cp0_int_o             (cp0_int_o),
    .excepttype_o          (excepttype_o),
    .current_inst_address_o(current_inst_address_o),
    .is_in_delayslot_o     (is_in_delayslot_o),
    .flush_o               (flush_o),
    .new_pc_o              (new_pc_o),
    .stall_o               (stall_o),
    .busy_o                (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    int_i = '0; timer_int_i = 1'b0; status_i = '0; cause_i = '0; epc_i = '0;
    mem_valid_i = 1'b0; mem_pc_i = '0; mem_in_delayslot_i = 1'b0;
    exc_syscall_i = 1'b0; exc_ri_i = 1'b0; exc_trap_i = 1'b0;
    exc_ov_i = 1'b0; exc_eret_i = 1'b0;
    stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0;
  endtask

  task automatic model_reset();
    m_left = 0; m_exc = '0; m_pc = '0; m_newpc = '0; m_ds = 1'b0;
    m_h0 = '0; m_h1 = '0;
  endtask

  // Highest-priority event from an ordered priority list; 0 when none.
  function automatic logic [31:0] model_code();
    logic [31:0] codes [6];
    logic [5:0]  f;
    logic        pend;
    logic [31:0] c;
    codes = '{32'h1, 32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    pend = status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 8'h0);
    f = {pend, exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, exc_eret_i};
    c = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (f[5-i] && c == 32'h0) c = codes[i];
    end
    return c;
  endfunction

  task automatic model_edge();
    logic [31:0] c;
    m_h1 = m_h0;
    m_h0 = int_i;
    m_exc = 32'h0;
    c = model_code();
    if (m_left > 0) begin
      m_left--;
    end else if (mem_valid_i && c != 32'h0) begin
      m_exc = c;
      m_pc  = mem_pc_i;
      m_ds  = mem_in_delayslot_i;
      if (c == 32'he) m_newpc = epc_i;
`ifdef EXC_CTRL_SPLIT_VEC_EN
      else if (c == 32'h1 && cause_i[23]) m_newpc = VEC + 32'h200;
`endif
      else m_newpc = VEC;
      m_left = FC;
    end
  endtask

  task automatic check_all();
    logic [5:0] es, ec;
    if (!rst || m_left > 0) es = 6'b000000;
    else if (stallreq_ex_i) es = 6'b001111;
    else if (stallreq_id_i) es = 6'b000111;
    else                    es = 6'b000000;
    ec = rst ? {m_h1[5] | timer_int_i, m_h1[4:0]} : 6'b0;
    chk("flush",   32'(flush_o),           32'(m_left > 0));
    chk("busy",    32'(busy_o),            32'(m_left > 0));
    chk("exctype", excepttype_o,           m_exc);
    chk("curaddr", current_inst_address_o, m_pc);
    chk("dslot",   32'(is_in_delayslot_o), 32'(m_ds));
    chk("newpc",   new_pc_o,               m_newpc);
    chk("stall",   32'(stall_o),           32'(es));
    chk("cp0int",  32'(cp0_int_o),         32'(ec));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_exc",   excepttype_o, 32'h0);
    chk("rst_newpc", new_pc_o,     32'h0);
    check_all();
    #2 rst = 1'b1;
    repeat (2) cyc();

    // syscall
    mem_valid_i = 1'b1; exc_syscall_i = 1'b1; mem_pc_i = 32'h100;
    cyc();
    chk("t1_exc",   excepttype_o, 32'h8);
    chk("t1_addr",  current_inst_address_o, 32'h100);
    chk("t1_flush", 32'(flush_o), 32'h1);
    chk("t1_newpc", new_pc_o, 32'h20);
    clr_in();
    repeat (FC) cyc();
    chk("t1_idle", 32'(busy_o), 32'h0);

    // hardware interrupt through the synchroniser
    int_i = 6'b000100;
    cyc();
    cyc();
    chk("t2_sync", 32'(cp0_int_o), 32'h4);
    status_i = 32'h0000_1001; cause_i = 32'h0000_1000; mem_valid_i = 1'b1;
    cyc();
    chk("t2_exc", excepttype_o, 32'h1);
    clr_in();
    cyc();
    chk("t2_onecyc", excepttype_o, 32'h0);
    repeat (FC) cyc();

    // eret vs ov, then eret alone
    mem_valid_i = 1'b1; exc_eret_i = 1'b1; exc_ov_i = 1'b1; epc_i = 32'h2C0;
    cyc();
    chk("t3_ov",    excepttype_o, 32'hc);
    chk("t3_ovpc",  new_pc_o, 32'h20);
    clr_in();
    repeat (FC) cyc();
    mem_valid_i = 1'b1; exc_eret_i = 1'b1; epc_i = 32'h2C0;
    cyc();
    chk("t3_eret",   excepttype_o, 32'he);
    chk("t3_eretpc", new_pc_o, 32'h2C0);
    clr_in();
    repeat (FC) cyc();

    // stall merge and override
    mem_valid_i = 1'b1; stallreq_ex_i = 1'b1; stallreq_id_i = 1'b1;
    cyc();
    chk("t4_stall", 32'(stall_o), 32'h0f);
    exc_ri_i = 1'b1;
    cyc();
    chk("t4_ovr", 32'(stall_o), 32'h0);
    chk("t4_ri",  excepttype_o, 32'ha);
    clr_in();
    repeat (FC) cyc();

    // interrupt masked by EXL, then taken; flush length
    status_i = 32'h0000_1003; cause_i = 32'h0000_1000; mem_valid_i = 1'b1;
    cyc();
    cyc();
    chk("t5_exl", 32'(busy_o), 32'h0);
    status_i = 32'h0000_1001; exc_syscall_i = 1'b1; stallreq_ex_i = 1'b1;
    cyc();
    chk("t5_int", excepttype_o, 32'h1);
    cyc();
    chk("t5_fl2", 32'(flush_o), 32'h1);
    cyc();
    chk("t5_fl3", 32'(flush_o), 32'h1);
    clr_in();
    cyc();
    chk("t5_fl4", 32'(flush_o), 32'h0);
    cyc();

    // asynchronous reset in the middle of a flush
    mem_valid_i = 1'b1; exc_trap_i = 1'b1; stallreq_ex_i = 1'b1; mem_pc_i = 32'h340;
    cyc();
    exc_trap_i = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_flush", 32'(flush_o), 32'h0);
    chk("t6_busy",  32'(busy_o), 32'h0);
    chk("t6_exc",   excepttype_o, 32'h0);
    chk("t6_stall", 32'(stall_o), 32'h0);
    check_all();
    #2 rst = 1'b1;
    clr_in();
    cyc();

    // vectored interrupt redirect
    status_i = 32'h0000_1001; cause_i = 32'h0080_1000; mem_valid_i = 1'b1;
    cyc();
`ifdef EXC_CTRL_SPLIT_VEC_EN
    chk("t6_ivpc", new_pc_o, 32'h220);
`else
    chk("t6_ivpc", new_pc_o, 32'h20);
`endif
    clr_in();
    repeat (FC) cyc();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
      timer_int_i        = ($urandom_range(0, 9) == 0);
      status_i           = {16'h0, 8'($urandom), 6'h0,
                            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
      cause_i            = {8'h0, 1'($urandom_range(0, 1)), 7'h0,
                            (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0), 8'h0};
      epc_i              = {$urandom, 2'b00} >> 2 << 2;
      mem_valid_i        = ($urandom_range(0, 3) != 0);
      mem_pc_i           = $urandom & 32'hffff_fffc;
      mem_in_delayslot_i = 1'($urandom_range(0, 1));
      exc_syscall_i      = ($urandom_range(0, 7) == 0);
      exc_ri_i           = ($urandom_range(0, 7) == 0);
      exc_trap_i         = ($urandom_range(0, 7) == 0);
      exc_ov_i           = ($urandom_range(0, 7) == 0);
      exc_eret_i         = ($urandom_range(0, 7) == 0);
      stallreq_id_i      = ($urandom_range(0, 2) == 0);
      stallreq_ex_i      = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
